// File: rtl/edsac_main_control_sequencer.sv
// EDSAC main control sequencer: alternates Stage 1 (fetch/transfer) and Stage 2 (execute) on d0 ticks.
// Optional single-step halting is compiled in with EDSAC_MCS_SINGLE_STEP_EN.
module edsac_main_control_sequencer #(
    parameter int unsigned EXEC_W        = 4,
    parameter int unsigned FETCH_TIMEOUT = 32,
    parameter int unsigned TMO_W         = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d0,
    input  logic              start,
    input  logic              addr_match,
    input  logic [EXEC_W-1:0] exec_len,
    input  logic              stop_order,
    input  logic              hold,
    input  logic              single_step,
    output logic              g12,
    output logic              g13,
    output logic              g1_pos,
    output logic              g1_neg,
    output logic              r2,
    output logic              sct_inc,
    output logic              ep_done,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [2:0] {StIdle, StFetch, StXfer, StExec, StHalt} state_t;

    state_t              state_q, state_d;
    logic                par_q, par_d;
    logic                pend_q, pend_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [EXEC_W-1:0]   cnt_q, cnt_d;
    logic                stop_q, stop_d;
    logic                fault_q, fault_d;
    logic                r2_d, sct_d, done_d;
    logic                halt_req;

`ifdef EDSAC_MCS_SINGLE_STEP_EN
    assign halt_req = stop_q | single_step;
`else
    logic unused_single_step;
    assign unused_single_step = single_step;
    assign halt_req = stop_q;
`endif

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        fault_d = fault_q;
        r2_d    = 1'b0;
        sct_d   = 1'b0;
        done_d  = 1'b0;
        par_d   = (d0 && state_q != StIdle) ? ~par_q : par_q;

        if ((state_q == StIdle || state_q == StHalt) && start) begin
            pend_d = 1'b1;
        end

        // pend_q (not start) gates the transition, so a start on a tick waits one more tick
        if (d0) begin
            unique case (state_q)
                StIdle, StHalt: begin
                    if (pend_q) begin
                        state_d = StFetch;
                        pend_d  = 1'b0;
                        tmo_d   = '0;
                    end
                end
                StFetch: begin
                    if (addr_match) begin
                        state_d = StXfer;
                    end else if (tmo_q == TMO_W'(FETCH_TIMEOUT - 1)) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                StXfer: begin
                    r2_d    = 1'b1;
                    sct_d   = 1'b1;
                    cnt_d   = (exec_len == '0) ? EXEC_W'(1) : exec_len;
                    stop_d  = stop_order;
                    state_d = StExec;
                end
                StExec: begin
                    if (!hold) begin
                        if (cnt_q <= EXEC_W'(1)) begin
                            done_d  = 1'b1;
                            tmo_d   = '0;
                            state_d = halt_req ? StHalt : StFetch;
                        end else begin
                            cnt_d = cnt_q - EXEC_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            par_q   <= 1'b0;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            fault_q <= 1'b0;
            g12     <= 1'b0;
            g13     <= 1'b0;
            halted  <= 1'b0;
            r2      <= 1'b0;
            sct_inc <= 1'b0;
            ep_done <= 1'b0;
        end else begin
            state_q <= state_d;
            par_q   <= par_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            fault_q <= fault_d;
            g12     <= (state_d == StFetch) || (state_d == StXfer);
            g13     <= (state_d == StExec);
            halted  <= (state_d == StHalt);
            r2      <= r2_d;
            sct_inc <= sct_d;
            ep_done <= done_d;
        end
    end

    assign g1_pos = par_q;
    assign g1_neg = ~par_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_edsac_main_control_sequencer.sv
// Self-checking bench for edsac_main_control_sequencer; order timing predicted from
// match delay, execution length and hold duration.
module tb_edsac_main_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d0 = 1'b0;
    logic       start = 1'b0;
    logic       addr_match = 1'b0;
    logic [3:0] exec_len = 4'd0;
    logic       stop_order = 1'b0;
    logic       hold = 1'b0;
    logic       single_step = 1'b0;
    logic       g12, g13, g1_pos, g1_neg, r2, sct_inc, ep_done, halted, fault;

    int errors = 0;
    int checks = 0;
    int r2_n = 0, sct_n = 0, done_n = 0, both_n = 0, mis_n = 0;

    edsac_main_control_sequencer #(
        .EXEC_W(4),
        .FETCH_TIMEOUT(32),
        .TMO_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .d0(d0),
        .start(start),
        .addr_match(addr_match),
        .exec_len(exec_len),
        .stop_order(stop_order),
        .hold(hold),
        .single_step(single_step),
        .g12(g12),
        .g13(g13),
        .g1_pos(g1_pos),
        .g1_neg(g1_neg),
        .r2(r2),
        .sct_inc(sct_inc),
        .ep_done(ep_done),
        .halted(halted),
        .fault(fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (r2) r2_n++;
        if (sct_inc) sct_n++;
        if (ep_done) done_n++;
        if (g12 && g13) both_n++;
        if (r2 !== sct_inc) mis_n++;
    end

    // One minor cycle of four clocks, d0 in the first.
    task automatic tick();
        @(negedge clk) d0 = 1'b1;
        @(negedge clk) d0 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic tick_with_start();
        @(negedge clk) begin d0 = 1'b1; start = 1'b1; end
        @(negedge clk) begin d0 = 1'b0; start = 1'b0; end
        repeat (3) @(negedge clk);
    endtask

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk) reset = 1'b1;
        addr_match = 1'b0; hold = 1'b0; stop_order = 1'b0; exec_len = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Runs one order from a freshly entered FETCH; match arrives on the m-th tick.
    task automatic do_order(input int m, input int len, input bit stp, input int hs, input int hl,
                            output int g12_n, output int g13_n, output int done_at);
        int dn;
        g12_n = int'(g12); g13_n = 0; done_at = -1;
        exec_len = 4'(len); stop_order = stp; hold = 1'b0; addr_match = 1'b0;
        for (int i = 1; i < m; i++) begin
            tick(); g12_n += int'(g12);
        end
        addr_match = 1'b1;
        tick(); g12_n += int'(g12);
        addr_match = 1'b0;
        tick(); g12_n += int'(g12); g13_n += int'(g13);
        for (int j = 1; j <= 40; j++) begin
            hold = ((j - 1) >= hs) && ((j - 1) < hs + hl);
            dn = done_n;
            tick();
            if (done_n != dn) done_at = j;
            if (!g13) break;
            g13_n++;
        end
        hold = 1'b0; stop_order = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({g12, g13, g1_pos, g1_neg, r2, sct_inc, ep_done, halted, fault} !== 9'b000100000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000100000",
                     {g12, g13, g1_pos, g1_neg, r2, sct_inc, ep_done, halted, fault});
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (g12 !== 1'b0 || g1_neg !== 1'b1 || halted !== 1'b0 || sct_n != 0) begin
            errors++;
            $display("FAIL idle_quiet: g12=%b g1_neg=%b halted=%b sct=%0d want 0 1 0 0",
                     g12, g1_neg, halted, sct_n);
        end
    endtask

    task automatic test_basic_order();
        int a, b, c, r0, s0, e0;
        apply_reset();
        start_pulse();
        tick();
        checks++;
        if (g12 !== 1'b1 || g1_pos !== 1'b0) begin
            errors++;
            $display("FAIL fetch_entry: g12=%b g1_pos=%b want 1 0", g12, g1_pos);
        end
        r0 = r2_n; s0 = sct_n; e0 = done_n;
        do_order(3, 3, 1'b0, 0, 0, a, b, c);
        checks++;
        if (a != 4) begin errors++; $display("FAIL basic_g12_len: got %0d want 4", a); end
        checks++;
        if (b != 3) begin errors++; $display("FAIL basic_g13_len: got %0d want 3", b); end
        checks++;
        if (r2_n - r0 != 1 || sct_n - s0 != 1 || done_n - e0 != 1) begin
            errors++;
            $display("FAIL basic_pulses: r2=%0d sct=%0d done=%0d want 1 1 1",
                     r2_n - r0, sct_n - s0, done_n - e0);
        end
        checks++;
        if (g12 !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL basic_refetch: g12=%b halted=%b want 1 0", g12, halted);
        end
        // 7 ticks outside IDLE since entry
        checks++;
        if (g1_pos !== 1'b1 || g1_neg !== 1'b0) begin
            errors++; $display("FAIL basic_parity: g1_pos=%b g1_neg=%b want 1 0", g1_pos, g1_neg);
        end
    endtask

    task automatic test_hold();
        int a, b, c;
        apply_reset();
        start_pulse();
        tick();
        do_order(1, 2, 1'b0, 1, 4, a, b, c);
        checks++;
        if (b != 6) begin errors++; $display("FAIL hold_g13_len: got %0d want 6", b); end
        checks++;
        if (c != 6) begin errors++; $display("FAIL hold_done_tick: got %0d want 6", c); end
    endtask

    task automatic test_stop_order();
        int a, b, c, e0;
        apply_reset();
        start_pulse();
        tick();
        e0 = done_n;
        do_order(2, 0, 1'b1, 0, 0, a, b, c);
        checks++;
        if (b != 1 || done_n - e0 != 1) begin
            errors++; $display("FAIL stop_exec: g13_len=%0d done=%0d want 1 1", b, done_n - e0);
        end
        checks++;
        if (halted !== 1'b1 || g12 !== 1'b0 || g13 !== 1'b0) begin
            errors++;
            $display("FAIL stop_halt: halted=%b g12=%b g13=%b want 1 0 0", halted, g12, g13);
        end
        tick_with_start();
        checks++;
        if (g12 !== 1'b0 || halted !== 1'b1) begin
            errors++; $display("FAIL coincident_start_early: g12=%b halted=%b want 0 1", g12, halted);
        end
        tick();
        checks++;
        if (g12 !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL coincident_start_resume: g12=%b halted=%b want 1 0", g12, halted);
        end
    endtask

    task automatic test_timeout();
        int a, b, c;
        apply_reset();
        start_pulse();
        tick();
        addr_match = 1'b0;
        repeat (31) tick();
        checks++;
        if (g12 !== 1'b1 || fault !== 1'b0) begin
            errors++; $display("FAIL timeout_early: g12=%b fault=%b want 1 0", g12, fault);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || fault !== 1'b1 || g12 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: halted=%b fault=%b g12=%b want 1 1 0", halted, fault, g12);
        end
        start_pulse();
        tick();
        checks++;
        if (g12 !== 1'b1 || fault !== 1'b1) begin
            errors++; $display("FAIL timeout_resume: g12=%b fault=%b want 1 1", g12, fault);
        end
        do_order(1, 1, 1'b1, 0, 0, a, b, c);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b1) begin
            errors++; $display("FAIL fault_sticky: halted=%b fault=%b want 1 1", halted, fault);
        end
    endtask

    task automatic test_single_step();
        int a, b, c, s0;
        apply_reset();
        single_step = 1'b1;
        start_pulse();
        tick();
        s0 = sct_n;
`ifdef EDSAC_MCS_SINGLE_STEP_EN
        for (int k = 0; k < 3; k++) begin
            do_order(1, 1, 1'b0, 0, 0, a, b, c);
            checks++;
            if (halted !== 1'b1) begin
                errors++; $display("FAIL step_halt_%0d: got %b want 1", k, halted);
            end
            if (k < 2) begin
                start_pulse();
                tick();
            end
        end
        checks++;
        if (sct_n - s0 != 3) begin
            errors++; $display("FAIL step_sct_count: got %0d want 3", sct_n - s0);
        end
`else
        for (int k = 0; k < 3; k++) do_order(1, 1, 1'b0, 0, 0, a, b, c);
        checks++;
        if (halted !== 1'b0 || g12 !== 1'b1 || sct_n - s0 != 3) begin
            errors++;
            $display("FAIL step_ignored: halted=%b g12=%b sct=%0d want 0 1 3", halted, g12, sct_n - s0);
        end
`endif
        single_step = 1'b0;
    endtask

    task automatic test_random_orders();
        int m, len, lp, hs, hl, a, b, c, r0, s0, e0, par;
        bit stp;
        apply_reset();
        start_pulse();
        tick();
        par = 0;
        for (int k = 0; k < 10; k++) begin
            m   = int'($urandom_range(1, 5));
            len = int'($urandom_range(0, 6));
            lp  = (len == 0) ? 1 : len;
            hs  = int'($urandom_range(0, lp - 1));
            hl  = int'($urandom_range(0, 3));
            stp = ($urandom_range(0, 3) == 0);
            r0 = r2_n; s0 = sct_n; e0 = done_n;
            do_order(m, len, stp, hs, hl, a, b, c);
            par += m + 1 + lp + hl;
            checks++;
            if (a != m + 1 || b != lp + hl || c != lp + hl) begin
                errors++;
                $display("FAIL rand_timing_%0d: g12=%0d g13=%0d done_at=%0d want %0d %0d %0d",
                         k, a, b, c, m + 1, lp + hl, lp + hl);
            end
            checks++;
            if (r2_n - r0 != 1 || sct_n - s0 != 1 || done_n - e0 != 1 || halted !== stp) begin
                errors++;
                $display("FAIL rand_pulses_%0d: r2=%0d sct=%0d done=%0d halted=%b want 1 1 1 %b",
                         k, r2_n - r0, sct_n - s0, done_n - e0, halted, stp);
            end
            checks++;
            if (g1_pos !== 1'(par % 2)) begin
                errors++; $display("FAIL rand_parity_%0d: got %b want %0d", k, g1_pos, par % 2);
            end
            if (stp) begin
                start_pulse();
                tick();
                par++;
            end
        end
        checks++;
        if (both_n != 0 || mis_n != 0) begin
            errors++; $display("FAIL exclusivity: overlap=%0d r2_vs_sct=%0d want 0 0", both_n, mis_n);
        end
    endtask

    task automatic test_reset_mid_exec();
        int e0, s0;
        apply_reset();
        start_pulse();
        tick();
        exec_len = 4'd5; addr_match = 1'b1;
        tick();
        addr_match = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (g13 !== 1'b1) begin errors++; $display("FAIL mid_exec_setup: g13=%b want 1", g13); end
        e0 = done_n; s0 = sct_n;
        @(negedge clk) reset = 1'b1;
        #1;
        checks++;
        if ({g12, g13, g1_pos, g1_neg, r2, sct_inc, ep_done, halted, fault} !== 9'b000100000) begin
            errors++;
            $display("FAIL async_reset: got %b want 000100000",
                     {g12, g13, g1_pos, g1_neg, r2, sct_inc, ep_done, halted, fault});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if (g12 !== 1'b0 || g13 !== 1'b0 || halted !== 1'b0 || g1_neg !== 1'b1 ||
            done_n != e0 || sct_n != s0) begin
            errors++;
            $display("FAIL post_reset_idle: g12=%b g13=%b halted=%b g1_neg=%b done=%0d sct=%0d",
                     g12, g13, halted, g1_neg, done_n - e0, sct_n - s0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_order();
        test_hold();
        test_stop_order();
        test_timeout();
        test_single_step();
        test_random_orders();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edsac_main_control_sequencer.md
Name: edsac_main_control_sequencer

Overview:
- Sequences the EDSAC main control through alternating Stage 1 (order fetch from store into order tank) and Stage 2 (order execution).
- Timing is locked to minor-cycle boundaries signalled by the digit pulse generator.
- Drives the stage gates g12 and g13, the odd/even cycle gates g1_pos and g1_neg, the order-loaded pulse r2, the sequence-control increment, and the execution-done pulse.
- Sits between the starter unit, the order coder, the store position comparator, and the arithmetic units.

Parameters:
- EXEC_W, 4, width of the execution-length field in minor cycles.
- FETCH_TIMEOUT, 32, maximum minor cycles spent in FETCH waiting for an address match before fault.
- TMO_W, 6, width of the fetch-timeout counter; must satisfy 2^TMO_W > FETCH_TIMEOUT.

Ports:
- clk  in  1  system clock (digit-period clock).
- reset  in  1  asynchronous, active-high reset.
- d0  in  1  one-clk pulse at digit position 0; marks the minor-cycle boundary ("tick").
- start  in  1  one-clk starter pulse; begins or resumes operation.
- addr_match  in  1  store position currently passing equals the sequence-control address; sampled at tick.
- exec_len  in  EXEC_W  minor cycles required by the decoded order; sampled in XFER.
- stop_order  in  1  decoded order is Z (stop); sampled in XFER.
- hold  in  1  arithmetic unit busy (e.g. multiplier awaiting ep4); extends EXEC.
- single_step  in  1  halt after each order (only when the optional feature is compiled in).
- g12  out  1  Stage 1 in progress.
- g13  out  1  Stage 2 in progress.
- g1_pos  out  1  odd minor cycle.
- g1_neg  out  1  even minor cycle.
- r2  out  1  one-clk pulse: order loaded into the order tank.
- sct_inc  out  1  one-clk pulse: increment the sequence control tank.
- ep_done  out  1  one-clk pulse: execution of the order complete.
- halted  out  1  sequencer is in the HALT state.
- fault  out  1  sticky flag: fetch timeout occurred.

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE; all outputs are 0 except g1_neg=1.
  - All counters are cleared and start_pend is cleared.
  - Reset asserted mid-operation aborts immediately, with no ep_done.
- Tick: the clk cycle in which d0=1. All state transitions except start latching occur only on a tick.
- Minor-cycle parity:
  - A parity flop toggles on every tick in all states except IDLE.
  - g1_pos equals the parity flop; g1_neg is its inverse.
- start latching:
  - In IDLE or HALT, start sets start_pend.
  - start is ignored in FETCH, XFER and EXEC.
- States:
  - IDLE: on a tick with start_pend set, go to FETCH and clear start_pend. A start coincident with a tick is latched and takes effect at the next tick, not the same one.
  - FETCH (g12=1):
    - At each tick, if addr_match=1, go to XFER.
    - Otherwise increment the timeout counter. When it reaches FETCH_TIMEOUT, set fault and go to HALT.
  - XFER (g12=1): lasts exactly one minor cycle. At its ending tick:
    - pulse r2 and sct_inc for one clk each, in the same cycle;
    - latch exec_len (a value of 0 is treated as 1) and stop_order;
    - go to EXEC.
  - EXEC (g13=1):
    - The down-counter is loaded with the latched length and decrements at each tick while hold=0; it freezes while hold=1.
    - When the counter reaches 0 at a tick with hold=0, pulse ep_done. Next state is HALT if stop_order was latched, otherwise FETCH.
    - On entering FETCH the timeout counter is cleared.
  - HALT (halted=1, g12=g13=0): on a tick with start_pend set, go to FETCH. fault is cleared only by reset.
- Exclusivity: g12 and g13 are never both 1. r2, sct_inc and ep_done never assert outside their defined cycles.
- Latency: start to g12 rising is 1–2 ticks. Fetch match to g13 rising is 1 minor cycle. Minimum order time is 1 fetch-match cycle plus 1 XFER cycle plus 1 EXEC minor cycle.

Optional Feature:
- Macro: EDSAC_MCS_SINGLE_STEP_EN.
- Defined:
  - At EXEC completion with single_step=1, go to HALT even when stop_order=0.
  - ep_done and sct_inc behave as normal.
  - start resumes at the next FETCH.
- Undefined: the single_step port exists but is ignored; only stop_order causes HALT.

Test Plan:
- Reset mid-EXEC (exec_len=5, after 2 ticks) -> all outputs 0 except g1_neg=1, state IDLE, no ep_done pulse; after reset release, no activity until start.
- start, then addr_match=1 on the 3rd tick in FETCH, exec_len=3, stop_order=0:
  - g12 high for 3 minor cycles plus 1 XFER cycle;
  - r2 and sct_inc pulse together once;
  - g13 high for exactly 3 minor cycles;
  - ep_done pulses once;
  - returns to FETCH with g12=1.
- exec_len=2 with hold=1 for 4 ticks mid-EXEC -> g13 lasts 6 minor cycles; ep_done pulses at the 6th tick.
- addr_match held 0 -> fault=1 and halted=1 after 32 ticks in FETCH; start then resumes FETCH; fault stays 1 until reset.
- Order with stop_order=1, exec_len=0 -> EXEC lasts 1 minor cycle, ep_done pulses, then HALT; start coincident with a tick in HALT -> FETCH entered at the following tick.
- With EDSAC_MCS_SINGLE_STEP_EN defined and single_step=1 -> HALT after each order; 3 start pulses yield exactly 3 sct_inc pulses. Without the macro -> continuous execution.
